// File: rtl/raizing_cen_pkg.sv
// raizing_cen_pkg
// Shared definitions for the multi-channel fractional clock-enable generator:
//   - default channel count and ratio/accumulator width
//   - standard enable ratios (NUM/DEN pairs, relative to a 48 MHz system clock)
//   - channel index names used by the game selector
package raizing_cen_pkg;

  localparam int unsigned DEFAULT_WIDTH = 10;
  localparam int unsigned DEFAULT_NCH   = 5;

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] num;
    logic [DEFAULT_WIDTH-1:0] den;
  } cen_ratio_t;

  // Enable rates in MHz from a 48 MHz clock
  localparam cen_ratio_t CEN_6P75   = '{num: 10'd9, den: 10'd64};
  localparam cen_ratio_t CEN_4      = '{num: 10'd1, den: 10'd12};
  localparam cen_ratio_t CEN_3P375  = '{num: 10'd9, den: 10'd128};
  localparam cen_ratio_t CEN_2      = '{num: 10'd1, den: 10'd24};
  localparam cen_ratio_t CEN_1P6875 = '{num: 10'd9, den: 10'd256};
  localparam cen_ratio_t CEN_1      = '{num: 10'd1, den: 10'd48};

  typedef enum logic [2:0] {
    CH_PXL = 3'd0,
    CH_Z80 = 3'd1,
    CH_FM  = 3'd2,
    CH_FM2 = 3'd3,
    CH_PCM = 3'd4
  } cen_chan_e;

endpackage

// File: rtl/raizing_cen_chan.sv
// raizing_cen_chan
// One fractional clock-enable channel: shadow ratio registers, phase
// accumulator, CEN compare and (optionally) the half-period CENB compare.
// Build option: CENGEN_BPHASE_EN enables the CENB logic; otherwise cenb is 0.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   num, den    : requested ratio, loaded into the shadows at safe points
//   hold        : freeze accumulator and shadows, suppress pulses
//   sync        : zero the accumulator, suppress pulses this cycle
//   cen, cenb   : registered one-cycle enable pulses
module raizing_cen_chan
  import raizing_cen_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  input  logic             hold,
  input  logic             sync,
  output logic             cen,
  output logic             cenb
);

  logic [WIDTH-1:0] snum;
  logic [WIDTH-1:0] sden;
  logic [WIDTH-1:0] acc;

  logic [WIDTH-1:0] step;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   wrap_val;
  logic [WIDTH-1:0] acc_nxt;
  logic             active;
  logic             fire;
  logic             load;
  logic             cenb_hit;

`ifdef CENGEN_BPHASE_EN
  logic [WIDTH-1:0] half;
`endif

  always_comb begin
    // A numerator above the denominator saturates at one pulse per cycle
    step     = (snum > sden) ? sden : snum;
    sum      = {1'b0, acc} + {1'b0, step};
    active   = (sden != '0);
    fire     = active && (sum >= {1'b0, sden});
    wrap_val = sum - {1'b0, sden};
    // Both branches fit in WIDTH bits: no-wrap means sum < sden,
    // wrap leaves a remainder below step
    acc_nxt  = fire ? wrap_val[WIDTH-1:0] : sum[WIDTH-1:0];
    // Shadows only move on a period boundary (or while idle), so a new
    // ratio never distorts the period already in progress
    load     = !hold && (!active || (fire && !sync));
  end

`ifdef CENGEN_BPHASE_EN
  always_comb begin
    half     = sden >> 1;
    cenb_hit = fire ? (wrap_val >= {1'b0, half})
                    : ((acc < half) && (sum >= {1'b0, half}));
    // Above half rate the B phase would collide with CEN
    if ({step, 1'b0} > {1'b0, sden})
      cenb_hit = 1'b0;
  end
`else
  always_comb begin
    cenb_hit = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snum <= '0;
      sden <= '0;
      acc  <= '0;
      cen  <= 1'b0;
      cenb <= 1'b0;
    end else begin
      cen  <= 1'b0;
      cenb <= 1'b0;
      if (sync) begin
        acc <= '0;
      end else if (!hold) begin
        if (active) begin
          acc  <= acc_nxt;
          cen  <= fire;
          cenb <= cenb_hit;
        end else begin
          acc <= '0;
        end
      end
      if (load) begin
        snum <= num;
        sden <= den;
      end
    end
  end

endmodule

// File: rtl/raizing_cen_gen.sv
// raizing_cen_gen
// Multi-channel fractional clock-enable generator. Each of NCH channels
// emits CEN at NUM/DEN of CLK with run-time, glitch-free ratio changes.
// Build option: CENGEN_BPHASE_EN enables the half-period CENB pulses;
// without it CENB is tied to 0.
// Ports:
//   CLK      : system clock
//   RESET_N  : asynchronous active-low reset
//   NUM, DEN : per-channel ratio, channel i at [i*WIDTH +: WIDTH]
//   HOLD     : per-channel freeze
//   SYNC     : zero all accumulators (phase realign), overrides HOLD
//   CEN      : per-channel enable pulse
//   CENB     : per-channel pulse half a period after CEN
module raizing_cen_gen
  import raizing_cen_pkg::*;
#(
  parameter int unsigned NCH   = DEFAULT_NCH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [NCH*WIDTH-1:0] NUM,
  input  logic [NCH*WIDTH-1:0] DEN,
  input  logic [NCH-1:0]       HOLD,
  input  logic                 SYNC,
  output logic [NCH-1:0]       CEN,
  output logic [NCH-1:0]       CENB
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    raizing_cen_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk  (CLK),
      .rst_n(RESET_N),
      .num  (NUM[i*WIDTH +: WIDTH]),
      .den  (DEN[i*WIDTH +: WIDTH]),
      .hold (HOLD[i]),
      .sync (SYNC),
      .cen  (CEN[i]),
      .cenb (CENB[i])
    );
  end

endmodule

// File: tb/tb_raizing_cen_gen.sv
// tb_raizing_cen_gen
// Self-checking bench for raizing_cen_gen. A reference model tracks each
// channel as a loaded ratio plus a starting phase and counts pulses with
// floor arithmetic; CEN/CENB are compared every cycle on the falling edge.
module tb_raizing_cen_gen;

  localparam int NCH = 5;
  localparam int W   = 10;

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic [NCH*W-1:0] NUM;
  logic [NCH*W-1:0] DEN;
  logic [NCH-1:0]   HOLD;
  logic             SYNC;
  logic [NCH-1:0]   CEN;
  logic [NCH-1:0]   CENB;

  int checks   = 0;
  int failures = 0;

  // model state: loaded ratio, phase at load, updates since load
  int             m_num  [NCH];
  int             m_den  [NCH];
  longint         m_base [NCH];
  longint         m_n    [NCH];
  logic [NCH-1:0] exp_cen;
  logic [NCH-1:0] exp_cenb;

  raizing_cen_gen #(
    .NCH  (NCH),
    .WIDTH(W)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .NUM    (NUM),
    .DEN    (DEN),
    .HOLD   (HOLD),
    .SYNC   (SYNC),
    .CEN    (CEN),
    .CENB   (CENB)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_ratio(input int ch, input int n, input int d);
    NUM[ch*W +: W] = n[W-1:0];
    DEN[ch*W +: W] = d[W-1:0];
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_num[i] = 0; m_den[i] = 0; m_base[i] = 0; m_n[i] = 0;
    end
    exp_cen  = '0;
    exp_cenb = '0;
  endtask

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      int     nm, dn;
      longint e, prev, cur, v, pv, h;
      bit     fire, b;
      nm = int'(NUM[i*W +: W]);
      dn = int'(DEN[i*W +: W]);
      exp_cen[i]  = 1'b0;
      exp_cenb[i] = 1'b0;
      if (SYNC) begin
        m_base[i] = 0; m_n[i] = 0;
        if (!HOLD[i] && m_den[i] == 0) begin m_num[i] = nm; m_den[i] = dn; end
      end else if (HOLD[i]) begin
        // frozen
      end else if (m_den[i] == 0) begin
        m_num[i] = nm; m_den[i] = dn; m_base[i] = 0; m_n[i] = 0;
      end else begin
        e    = (m_num[i] > m_den[i]) ? m_den[i] : m_num[i];
        prev = m_base[i] + m_n[i] * e;
        m_n[i]++;
        cur  = m_base[i] + m_n[i] * e;
        fire = (cur / m_den[i]) != (prev / m_den[i]);
        v    = cur % m_den[i];
        pv   = prev % m_den[i];
        h    = m_den[i] / 2;
        b    = fire ? (v >= h) : ((pv < h) && (v >= h));
        if (2 * e > m_den[i]) b = 1'b0;
        exp_cen[i] = fire;
`ifdef CENGEN_BPHASE_EN
        exp_cenb[i] = b;
`else
        exp_cenb[i] = 1'b0 & b;
`endif
        if (fire) begin
          m_base[i] = v; m_n[i] = 0; m_num[i] = nm; m_den[i] = dn;
        end
      end
    end
  endtask

  // advance one clock: model sees the inputs the DUT samples, then wait for
  // the falling edge where outputs are compared
  task automatic cycle();
    @(posedge CLK);
    if (!RESET_N) model_reset();
    else model_step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    HOLD    = '0;
    SYNC    = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    #1;
    checks++;
    if (CEN !== '0) begin failures++; $display("FAIL reset_cen got=%b exp=0", CEN); end
    checks++;
    if (CENB !== '0) begin failures++; $display("FAIL reset_cenb got=%b exp=0", CENB); end
    do_reset();
    cycle();
    checks++;
    if (CEN !== '0) begin failures++; $display("FAIL release_cycle_cen got=%b exp=0", CEN); end
  endtask

  task automatic test_rates();
    int last0 = -1, first0 = -1, periods = 0, bad_period = 0, bad_b = 0;
    int last1 = -1, cnt1 = 0, bad_gap = 0;
    set_ratio(0, 1, 12);
    set_ratio(1, 9, 128);
    set_ratio(2, int'(raizing_cen_pkg::CEN_6P75.num), int'(raizing_cen_pkg::CEN_6P75.den));
    set_ratio(3, int'(raizing_cen_pkg::CEN_1.num), int'(raizing_cen_pkg::CEN_1.den));
    set_ratio(4, int'(raizing_cen_pkg::CEN_1P6875.num), int'(raizing_cen_pkg::CEN_1P6875.den));
    do_reset();
    for (int k = 1; k <= 12801; k++) begin
      cycle();
      checks++;
      if (CEN !== exp_cen) begin failures++; $display("FAIL rates_cen k=%0d got=%b exp=%b", k, CEN, exp_cen); end
      checks++;
      if (CENB !== exp_cenb) begin failures++; $display("FAIL rates_cenb k=%0d got=%b exp=%b", k, CENB, exp_cenb); end
      if (CEN[0]) begin
        if (first0 < 0) first0 = k;
        else if (periods < 1000) begin
          if (k - last0 != 12) bad_period++;
          periods++;
        end
        last0 = k;
      end
`ifdef CENGEN_BPHASE_EN
      if (CENB[0] && last0 > 0 && (k - last0) != 6) bad_b++;
`endif
      if (CEN[1]) begin
        cnt1++;
        if (last1 > 0 && (k - last1) != 14 && (k - last1) != 15) bad_gap++;
        last1 = k;
      end
    end
    checks++;
    if (first0 != 13) begin failures++; $display("FAIL first_cen_1_12 got=%0d exp=13", first0); end
    checks++;
    if (periods != 1000 || bad_period != 0) begin
      failures++; $display("FAIL period_1_12 periods=%0d bad=%0d exp=1000/0", periods, bad_period);
    end
    checks++;
    if (cnt1 != 900) begin failures++; $display("FAIL count_9_128 got=%0d exp=900", cnt1); end
    checks++;
    if (bad_gap != 0) begin failures++; $display("FAIL gap_9_128 bad=%0d exp=0", bad_gap); end
    checks++;
    if (bad_b != 0) begin failures++; $display("FAIL cenb_offset bad=%0d exp=0", bad_b); end
  endtask

  task automatic test_ratio_switch();
    int p [3];
    int np = 0;
    set_ratio(0, 1, 12);
    do_reset();
    for (int k = 1; k <= 150; k++) begin
      cycle();
      checks++;
      if (CEN !== exp_cen) begin failures++; $display("FAIL switch_cen k=%0d got=%b exp=%b", k, CEN, exp_cen); end
      if (CEN[0] && np < 3) begin p[np] = k; np++; end
      if (k == 18) set_ratio(0, 9, 256);
    end
    checks++;
    if (np != 3 || p[0] != 13 || p[1] != 25 || p[2] != 54) begin
      failures++;
      $display("FAIL switch_pulses n=%0d got=%0d,%0d,%0d exp=13,25,54", np, p[0], p[1], p[2]);
    end
  endtask

  task automatic test_hold();
    int second = -1, first = -1, in_hold = 0;
    set_ratio(0, 1, 12);
    do_reset();
    for (int k = 1; k <= 120; k++) begin
      cycle();
      checks++;
      if (CEN !== exp_cen) begin failures++; $display("FAIL hold_cen k=%0d got=%b exp=%b", k, CEN, exp_cen); end
      if (CEN[0]) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      if (k >= 17 && k <= 66 && (CEN[0] || CENB[0])) in_hold++;
      if (k == 16) HOLD[0] = 1'b1;
      if (k == 66) HOLD[0] = 1'b0;
    end
    checks++;
    if (in_hold != 0) begin failures++; $display("FAIL hold_quiet got=%0d exp=0", in_hold); end
    checks++;
    if (first != 13 || second != 75) begin
      failures++; $display("FAIL hold_offset got=%0d,%0d exp=13,75", first, second);
    end
  endtask

  task automatic test_sync();
    int f0 = -1, f1 = -1, coinc = 0, orphan = 0;
    set_ratio(0, 1, 12);
    set_ratio(1, 1, 24);
    do_reset();
    repeat ($urandom_range(60, 30)) begin
      cycle();
      checks++;
      if (CEN !== exp_cen) begin failures++; $display("FAIL presync_cen got=%b exp=%b", CEN, exp_cen); end
    end
    SYNC = 1'b1;
    for (int j = 1; j <= 80; j++) begin
      cycle();
      SYNC = 1'b0;
      checks++;
      if (CEN !== exp_cen) begin failures++; $display("FAIL sync_cen j=%0d got=%b exp=%b", j, CEN, exp_cen); end
      if (CEN[0] && f0 < 0) f0 = j;
      if (CEN[1] && f1 < 0) f1 = j;
      if (CEN[0] && CEN[1]) coinc++;
      if (CEN[1] && !CEN[0]) orphan++;
    end
    checks++;
    if (f0 != 13 || f1 != 25) begin failures++; $display("FAIL sync_first got=%0d,%0d exp=13,25", f0, f1); end
    checks++;
    if (coinc != 3 || orphan != 0) begin
      failures++; $display("FAIL sync_coincident got=%0d/%0d exp=3/0", coinc, orphan);
    end
  endtask

  task automatic test_edges();
    int c0 = 0, c1 = 0, c2 = 0, b2 = 0;
    set_ratio(0, 5, 0);
    set_ratio(1, 0, 7);
    set_ratio(2, 20, 10);
    set_ratio(3, 1, 2);
    set_ratio(4, 3, 7);
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      cycle();
      checks++;
      if (CEN !== exp_cen) begin failures++; $display("FAIL edge_cen k=%0d got=%b exp=%b", k, CEN, exp_cen); end
      checks++;
      if (CENB !== exp_cenb) begin failures++; $display("FAIL edge_cenb k=%0d got=%b exp=%b", k, CENB, exp_cenb); end
      c0 += int'(CEN[0]); c1 += int'(CEN[1]); c2 += int'(CEN[2]); b2 += int'(CENB[2]);
    end
    checks++;
    if (c0 != 0) begin failures++; $display("FAIL den_zero got=%0d exp=0", c0); end
    checks++;
    if (c1 != 0) begin failures++; $display("FAIL num_zero got=%0d exp=0", c1); end
    checks++;
    if (c2 != 199 || b2 != 0) begin failures++; $display("FAIL clamp_20_10 cen=%0d cenb=%0d exp=199/0", c2, b2); end
    #2;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (CEN !== '0) begin failures++; $display("FAIL midrun_reset_cen got=%b exp=0", CEN); end
    @(negedge CLK);
    model_reset();
    RESET_N = 1'b1;
    cycle();
    checks++;
    if (CEN !== '0 || exp_cen !== '0) begin
      failures++; $display("FAIL post_reset_cen got=%b exp=0", CEN);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < NCH; i++)
      set_ratio(i, int'($urandom_range(40)), int'($urandom_range(400, 41)));
    do_reset();
    for (int k = 1; k <= 4000; k++) begin
      if ($urandom_range(99) < 3) begin
        int ch, n, d;
        ch = int'($urandom_range(NCH-1));
        n  = int'($urandom_range(40));
        d  = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(400, 41));
        set_ratio(ch, n, d);
      end
      if ($urandom_range(99) < 4) begin
        int hc;
        hc = int'($urandom_range(NCH-1));
        HOLD[hc] = ~HOLD[hc];
      end
      SYNC = ($urandom_range(99) < 2);
      cycle();
      checks++;
      if (CEN !== exp_cen) begin failures++; $display("FAIL random_cen k=%0d got=%b exp=%b", k, CEN, exp_cen); end
      checks++;
      if (CENB !== exp_cenb) begin failures++; $display("FAIL random_cenb k=%0d got=%b exp=%b", k, CENB, exp_cenb); end
    end
    HOLD = '0;
    SYNC = 1'b0;
  endtask

  initial begin
    NUM  = '0;
    DEN  = '0;
    HOLD = '0;
    SYNC = 1'b0;
    model_reset();
    test_reset();
    test_rates();
    test_ratio_switch();
    test_hold();
    test_sync();
    test_edges();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
